// File: rtl/align_tx_scheduler.sv
// Transmit-side ALIGN scheduler: merges link-layer primitives and frame data,
// inserting an ALIGN pair every ALIGN_INTERVAL dwords and after every link-up.
module align_tx_scheduler #(
   parameter int unsigned ALIGN_INTERVAL = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        phy_ready,
   input  logic [31:0] ll_prim,
   input  logic        ll_prim_req,
   input  logic [31:0] data_din,
   input  logic        data_valid,
   output logic        data_ready,
   output logic [31:0] tx_dout,
   output logic        tx_isk,
   output logic        last_prim,
   output logic        align_active
);

   localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;
   localparam logic [31:0] PRIM_SYNC  = 32'hB5B5_957C;
   localparam logic [15:0] LAST_CNT   = 16'(ALIGN_INTERVAL - 1);

   typedef enum logic [1:0] {
      WAIT_PHY = 2'd0,
      NORMAL   = 2'd1,
      ALIGN0   = 2'd2,
      ALIGN1   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] tx_dout_q, tx_dout_d;
   logic        tx_isk_q, tx_isk_d;
   logic        last_prim_q, last_prim_d;
   logic        align_active_q, align_active_d;
   logic        at_end;
   logic [31:0] prim_sel;

   assign at_end     = (cnt_q == LAST_CNT);
   assign data_ready = (state_q == NORMAL) && phy_ready && !at_end;
   assign prim_sel   = ll_prim_req ? ll_prim : PRIM_SYNC;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      tx_dout_d      = PRIM_ALIGN;
      tx_isk_d       = 1'b1;
      last_prim_d    = 1'b0;
      align_active_d = 1'b0;
      if (!phy_ready) begin
         state_d = WAIT_PHY;
         cnt_d   = '0;
      end else begin
         case (state_q)
            WAIT_PHY: begin
               state_d = ALIGN0;
               cnt_d   = '0;
            end
            ALIGN0: begin
               state_d        = ALIGN1;
               cnt_d          = '0;
               align_active_d = 1'b1;
            end
            ALIGN1: begin
               state_d        = NORMAL;
               align_active_d = 1'b1;
            end
            NORMAL: begin
               cnt_d = cnt_q + 16'd1;
               if (at_end) begin
                  state_d = ALIGN0;
                  cnt_d   = '0;
               end
               // align_active_q high here means the previous cycle was ALIGN1,
               // i.e. this is the first NORMAL cycle and CONT must restart.
               if (data_valid && data_ready) begin
                  tx_dout_d   = data_din;
                  tx_isk_d    = 1'b0;
                  last_prim_d = align_active_q;
               end else begin
                  tx_dout_d   = prim_sel;
                  last_prim_d = at_end || align_active_q || (prim_sel != tx_dout_q);
               end
            end
            default: state_d = WAIT_PHY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= WAIT_PHY;
         cnt_q          <= '0;
         tx_dout_q      <= PRIM_ALIGN;
         tx_isk_q       <= 1'b1;
         last_prim_q    <= 1'b0;
         align_active_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         tx_dout_q      <= tx_dout_d;
         tx_isk_q       <= tx_isk_d;
         last_prim_q    <= last_prim_d;
         align_active_q <= align_active_d;
      end
   end

   assign tx_dout      = tx_dout_q;
   assign tx_isk       = tx_isk_q;
   assign last_prim    = last_prim_q;
   assign align_active = align_active_q;

endmodule

// File: tb/tb_align_tx_scheduler.sv
// Directed bench for align_tx_scheduler with ALIGN_INTERVAL=8.
module tb_align_tx_scheduler;

   localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
   localparam logic [31:0] SYNC  = 32'hB5B5_957C;
   localparam logic [31:0] HOLD  = 32'hD5D5_AA7C;
   localparam logic [31:0] DBASE = 32'hD000_0000;

   logic        clk = 1'b0;
   logic        rst_n, phy_ready, ll_prim_req, data_valid;
   logic [31:0] ll_prim, data_din, tx_dout;
   logic        data_ready, tx_isk, last_prim, align_active;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          k = 0;

   always #5 clk = ~clk;

   align_tx_scheduler #(.ALIGN_INTERVAL(8)) dut (
      .clk(clk), .rst_n(rst_n), .phy_ready(phy_ready),
      .ll_prim(ll_prim), .ll_prim_req(ll_prim_req),
      .data_din(data_din), .data_valid(data_valid), .data_ready(data_ready),
      .tx_dout(tx_dout), .tx_isk(tx_isk), .last_prim(last_prim),
      .align_active(align_active)
   );

   task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] dout, input logic isk,
                      input logic lp, input logic aa);
      cmp({tag, ".dout"}, tx_dout, dout);
      cmp({tag, ".isk"}, 32'(tx_isk), 32'(isk));
      cmp({tag, ".last_prim"}, 32'(last_prim), 32'(lp));
      cmp({tag, ".align_active"}, 32'(align_active), 32'(aa));
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; phy_ready = 1'b1; ll_prim_req = 1'b0; ll_prim = '0;
      data_valid = 1'b0; data_din = DBASE;
      repeat (3) tick();
      chk("reset", ALIGN, 1, 0, 0);
      cmp("reset.data_ready", 32'(data_ready), 0);

      // link-up ALIGN pair, then SYNC
      rst_n = 1'b1;
      tick(); chk("wait_phy", ALIGN, 1, 0, 0);
      tick(); chk("align0", ALIGN, 1, 0, 1);
      tick(); chk("align1", ALIGN, 1, 0, 1);
      cmp("n0.data_ready", 32'(data_ready), 1);
      tick(); chk("sync_first", SYNC, 1, 1, 0);
      tick(); chk("sync_rep", SYNC, 1, 0, 0);
      for (int i = 2; i < 7; i++) begin
         tick(); chk("sync_mid", SYNC, 1, 0, 0);
      end
      cmp("end.data_ready", 32'(data_ready), 0);
      tick(); chk("sync_end", SYNC, 1, 1, 0);
      tick(); chk("p1.align0", ALIGN, 1, 0, 1);
      tick(); chk("p1.align1", ALIGN, 1, 0, 1);

      // continuous data: 7 dwords per window, no loss across the ALIGN pair
      data_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         cmp("b.data_ready", 32'(data_ready), 1);
         tick(); chk("b.data", DBASE + 32'(k), 0, (i == 0), 0);
         k++; data_din = DBASE + 32'(k);
      end
      cmp("b.end_ready", 32'(data_ready), 0);
      tick(); chk("b.end_sync", SYNC, 1, 1, 0);
      cmp("b.align_ready", 32'(data_ready), 0);
      tick(); chk("b.align0", ALIGN, 1, 0, 1);
      tick(); chk("b.align1", ALIGN, 1, 0, 1);

      // data and primitive both requested: data wins
      ll_prim_req = 1'b1; ll_prim = HOLD;
      for (int i = 0; i < 7; i++) begin
         tick(); chk("c.data", DBASE + 32'(k), 0, (i == 0), 0);
         k++; data_din = DBASE + 32'(k);
      end
      tick(); chk("c.end_hold", HOLD, 1, 1, 0);
      tick(); chk("c.align0", ALIGN, 1, 0, 1);
      tick(); chk("c.align1", ALIGN, 1, 0, 1);

      // HOLD for 20 cycles spanning two ALIGN pairs
      data_valid = 1'b0;
      for (int p = 0; p < 20; p++) begin
         tick();
         if ((p % 10) >= 8) chk("d.align", ALIGN, 1, 0, 1);
         else chk("d.hold", HOLD, 1, ((p % 10) == 0) || ((p % 10) == 7), 0);
      end

      // back to SYNC, then drop phy_ready while in ALIGN0
      ll_prim_req = 1'b0;
      tick(); chk("e.sync_first", SYNC, 1, 1, 0);
      for (int i = 1; i < 7; i++) begin
         tick(); chk("e.sync", SYNC, 1, 0, 0);
      end
      tick(); chk("e.sync_end", SYNC, 1, 1, 0);
      phy_ready = 1'b0;
      cmp("e.drop_ready0", 32'(data_ready), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         cmp("e.drop_dout", tx_dout, ALIGN);
         cmp("e.drop_ready", 32'(data_ready), 0);
      end
      phy_ready = 1'b1;
      tick(); chk("e.rec_wait", ALIGN, 1, 0, 0);
      tick(); chk("e.rec_align0", ALIGN, 1, 0, 1);
      tick(); chk("e.rec_align1", ALIGN, 1, 0, 1);
      for (int i = 0; i < 7; i++) begin
         cmp("e.rec_ready", 32'(data_ready), 1);
         tick(); chk("e.rec_sync", SYNC, 1, (i == 0), 0);
      end
      cmp("e.rec_end_ready", 32'(data_ready), 0);
      tick(); chk("e.rec_sync_end", SYNC, 1, 1, 0);
      tick(); chk("e.rec2_align0", ALIGN, 1, 0, 1);
      tick(); chk("e.rec2_align1", ALIGN, 1, 0, 1);

      // asynchronous reset with data in flight
      data_valid = 1'b1;
      tick(); chk("f.data", DBASE + 32'(k), 0, 1, 0);
      k++; data_din = DBASE + 32'(k);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("f.async_rst", ALIGN, 1, 0, 0);
      cmp("f.async_ready", 32'(data_ready), 0);
      #10;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
